// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the parity_type encodings, the frame FSM state type and the minimum
// supported data length. No ports; imported by every UART TX file.
package uart_pkg;

  // parity_type encodings; 2'b11 behaves as "no parity"
  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_ODD      = 2'b01;
  localparam logic [1:0] PAR_EVEN     = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  // Smallest data length a frame may carry; shorter requests are raised to it
  localparam int DATA_MIN = 5;

  // Frame FSM: the state names the bit currently on the line
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_parity_gen.sv
// Parity bit generator for one UART frame.
// Ports:
//   data    in  DATA_W  frame payload
//   len     in  LEN_W   number of valid payload bits (already clamped)
//   ptype   in  2       parity_type encoding from uart_pkg
//   par_bit out 1       parity bit value to transmit
//   par_en  out 1       high when the frame carries a parity bit
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        ptype,
  output logic              par_bit,
  output logic              par_en
);

  // XOR of the low n bits only; bits at or above n must not influence parity
  function automatic logic masked_xor(input logic [DATA_W-1:0] d,
                                      input logic [LEN_W-1:0]  n);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(n)) begin
        acc = acc ^ d[i];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  logic xor_s;

  // Parity bit selection: odd inverts the data XOR so the total ones count is odd
  always_comb begin
    xor_s   = masked_xor(data, len);
    par_bit = 1'b0;
    par_en  = 1'b0;
    case (ptype)
      PAR_ODD: begin
        par_en  = 1'b1;
        par_bit = ~xor_s;
      end
      PAR_EVEN: begin
        par_en  = 1'b1;
        par_bit = xor_s;
      end
      PAR_NONE, PAR_NONE_ALT: begin
        par_en  = 1'b0;
        par_bit = 1'b0;
      end
      default: begin
        par_en  = 1'b0;
        par_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_frame_piso.sv
// UART transmit serialiser with runtime data length, parity, 1/2 stop bits
// and a one-deep holding register for back-to-back frames.
// Ports:
//   baud_clk    in  1       one tick per bit period
//   reset_n     in  1       asynchronous active-low reset
//   send        in  1       frame request, taken on an edge with send && ready
//   reg_data    in  DATA_W  payload, LSB first on the line
//   data_len    in  LEN_W   data bits per frame, clamped to [DATA_MIN, DATA_W]
//   parity_type in  2       none / odd / even / none
//   stop_bits   in  1       0 = one stop bit, 1 = two
//   data_tx     out 1       serial line, idle high
//   active_flag out 1       high while a frame bit is driven
//   done_flag   out 1       one-cycle pulse after the last stop bit
//   ready       out 1       holding register empty
module uart_tx_frame_piso
  import uart_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              baud_clk,
  input  logic              reset_n,
  input  logic              send,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [LEN_W-1:0]  data_len,
  input  logic [1:0]        parity_type,
  input  logic              stop_bits,
  output logic              data_tx,
  output logic              active_flag,
  output logic              done_flag,
  output logic              ready
);

  // Clamp applied once at accept so the counter never sees an illegal length
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len < LEN_W'(DATA_MIN)) begin
      return LEN_W'(DATA_MIN);
    end else if (len > LEN_W'(DATA_W)) begin
      return LEN_W'(DATA_W);
    end else begin
      return len;
    end
  endfunction

  tx_state_t         state_r;
  logic [DATA_W-1:0] shift_r;
  logic [LEN_W-1:0]  bit_cnt_r;
  logic              par_bit_r;
  logic              par_en_r;
  logic              stop2_r;
  logic              stop_cnt_r;
  logic [DATA_W-1:0] hold_data_r;
  logic [LEN_W-1:0]  hold_len_r;
  logic [1:0]        hold_ptype_r;
  logic              hold_stop_r;
  logic              ready_r;      // 1 = holding register empty
  logic              data_tx_r;
  logic              active_r;
  logic              done_r;

  logic              accept_s;
  logic              last_stop_s;
  logic              start_load_s;
  logic              to_hold_s;
  logic [DATA_W-1:0] load_data_s;
  logic [LEN_W-1:0]  load_len_s;
  logic [1:0]        load_ptype_s;
  logic              load_stop_s;
  logic              load_par_bit_s;
  logic              load_par_en_s;

  // Load source: a full holding register always wins over the live inputs
  always_comb begin
    accept_s    = send && ready_r;
    last_stop_s = (state_r == ST_STOP) && !stop_cnt_r;
    if (ready_r) begin
      load_data_s  = reg_data;
      load_len_s   = clamp_len(data_len);
      load_ptype_s = parity_type;
      load_stop_s  = stop_bits;
    end else begin
      load_data_s  = hold_data_r;
      load_len_s   = hold_len_r;
      load_ptype_s = hold_ptype_r;
      load_stop_s  = hold_stop_r;
    end
    // New frame enters the shifter from IDLE or seamlessly at the last stop edge
    start_load_s = ((state_r == ST_IDLE) && accept_s) ||
                   (last_stop_s && (!ready_r || send));
    to_hold_s    = accept_s && !start_load_s;
  end

  uart_parity_gen #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_parity (
    .data    (load_data_s),
    .len     (load_len_s),
    .ptype   (load_ptype_s),
    .par_bit (load_par_bit_s),
    .par_en  (load_par_en_s)
  );

  // Frame FSM, shifter, bit counter, holding register and registered outputs
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      par_bit_r    <= 1'b0;
      par_en_r     <= 1'b0;
      stop2_r      <= 1'b0;
      stop_cnt_r   <= 1'b0;
      hold_data_r  <= '0;
      hold_len_r   <= '0;
      hold_ptype_r <= 2'b00;
      hold_stop_r  <= 1'b0;
      ready_r      <= 1'b1;
      data_tx_r    <= 1'b1;
      active_r     <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (to_hold_s) begin
        hold_data_r  <= reg_data;
        hold_len_r   <= clamp_len(data_len);
        hold_ptype_r <= parity_type;
        hold_stop_r  <= stop_bits;
        ready_r      <= 1'b0;
      end
      if (start_load_s) begin
        // Start bit goes out from this edge; holding register frees up here
        state_r   <= ST_START;
        shift_r   <= load_data_s;
        bit_cnt_r <= load_len_s - LEN_W'(1);
        par_bit_r <= load_par_bit_s;
        par_en_r  <= load_par_en_s;
        stop2_r   <= load_stop_s;
        ready_r   <= 1'b1;
        data_tx_r <= 1'b0;
        active_r  <= 1'b1;
        done_r    <= last_stop_s;
      end else begin
        case (state_r)
          ST_IDLE: begin
            data_tx_r <= 1'b1;
            active_r  <= 1'b0;
          end
          ST_START: begin
            state_r   <= ST_DATA;
            data_tx_r <= shift_r[0];
            shift_r   <= shift_r >> 1;
          end
          ST_DATA: begin
            if (bit_cnt_r == '0) begin
              if (par_en_r) begin
                state_r   <= ST_PARITY;
                data_tx_r <= par_bit_r;
              end else begin
                state_r    <= ST_STOP;
                data_tx_r  <= 1'b1;
                stop_cnt_r <= stop2_r;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r - LEN_W'(1);
              data_tx_r <= shift_r[0];
              shift_r   <= shift_r >> 1;
            end
          end
          ST_PARITY: begin
            state_r    <= ST_STOP;
            data_tx_r  <= 1'b1;
            stop_cnt_r <= stop2_r;
          end
          ST_STOP: begin
            if (stop_cnt_r) begin
              stop_cnt_r <= 1'b0;
            end else begin
              state_r   <= ST_IDLE;
              data_tx_r <= 1'b1;
              active_r  <= 1'b0;
              done_r    <= 1'b1;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            data_tx_r <= 1'b1;
            active_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_tx     = data_tx_r;
  assign active_flag = active_r;
  assign done_flag   = done_r;
  assign ready       = ready_r;

endmodule

// File: tb/tb_uart_tx_frame_piso.sv
// Directed self-checking bench for uart_tx_frame_piso (DATA_W = 9).
module tb_uart_tx_frame_piso;

  logic       baud_clk;
  logic       reset_n;
  logic       send;
  logic [8:0] reg_data;
  logic [3:0] data_len;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;
  logic       ready;

  int checks;
  int failures;

  uart_tx_frame_piso #(.DATA_W(9)) dut (
    .baud_clk    (baud_clk),
    .reset_n     (reset_n),
    .send        (send),
    .reg_data    (reg_data),
    .data_len    (data_len),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .ready       (ready)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k of the result is character k of s (first transmitted bit first)
  function automatic logic [63:0] bits_of(input string s);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v[i] = (s[i] == 8'h31);
    return v;
  endfunction

  // Issue one frame from idle and compare the line against the expected bit string
  task automatic run_frame(input string tag, input logic [8:0] d, input logic [3:0] len,
                           input logic [1:0] pt, input logic st, input string exp);
    logic [63:0] seq;
    int n, ndone, inact, notrdy;
    n = exp.len(); seq = '0; ndone = 0; inact = 0; notrdy = 0;
    @(negedge baud_clk);
    reg_data = d; data_len = len; parity_type = pt; stop_bits = st; send = 1'b1;
    @(negedge baud_clk);
    // Scramble inputs: the frame must use the values latched at accept
    send = 1'b0; reg_data = ~d; data_len = 4'd8; parity_type = ~pt; stop_bits = ~st;
    for (int k = 0; k < n; k++) begin
      seq[k] = data_tx;
      if (done_flag)    ndone++;
      if (!active_flag) inact++;
      if (!ready)       notrdy++;
      @(negedge baud_clk);
    end
    check_eq({tag, "_bits"}, seq, bits_of(exp));
    check_eq({tag, "_done_in"}, 64'(ndone), 64'd0);
    check_eq({tag, "_active"}, 64'(inact), 64'd0);
    check_eq({tag, "_ready"}, 64'(notrdy), 64'd0);
    check_eq({tag, "_done_end"}, 64'(done_flag), 64'd1);
    check_eq({tag, "_idle_act"}, 64'(active_flag), 64'd0);
    check_eq({tag, "_idle_tx"}, 64'(data_tx), 64'd1);
    @(negedge baud_clk);
    check_eq({tag, "_done_off"}, 64'(done_flag), 64'd0);
  endtask

  logic [63:0] seq6;
  int accepts, dones6, falls6;
  logic rdy_prev, rdy_obs;
  logic [8:0] vals [3];

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; send = 1'b0; reg_data = 9'd0; data_len = 4'd8;
    parity_type = 2'b00; stop_bits = 1'b0;
    repeat (3) @(negedge baud_clk);
    check_eq("rst_tx", 64'(data_tx), 64'd1);
    check_eq("rst_active", 64'(active_flag), 64'd0);
    check_eq("rst_done", 64'(done_flag), 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd1);
    reset_n = 1'b1;

    // 1: reset mid-frame with a full holding register
    @(negedge baud_clk);
    reg_data = 9'h04A; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0; send = 1'b1;
    @(negedge baud_clk);
    @(negedge baud_clk);
    send = 1'b0;
    check_eq("t1_held", 64'(ready), 64'd0);
    check_eq("t1_busy", 64'(active_flag), 64'd1);
    @(negedge baud_clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t1_async_tx", 64'(data_tx), 64'd1);
    check_eq("t1_async_act", 64'(active_flag), 64'd0);
    check_eq("t1_async_rdy", 64'(ready), 64'd1);
    check_eq("t1_async_done", 64'(done_flag), 64'd0);
    dones6 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge baud_clk);
      if (done_flag) dones6++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge baud_clk);
      if (done_flag || active_flag || !data_tx) dones6++;
    end
    check_eq("t1_no_resume", 64'(dones6), 64'd0);

    // 2-5: single frames from idle
    run_frame("t2_none",   9'h04A, 4'd8,  2'b00, 1'b0, "0010100101");
    run_frame("t3_odd",    9'h04A, 4'd8,  2'b01, 1'b0, "00101001001");
    run_frame("t3_even",   9'h04A, 4'd8,  2'b10, 1'b0, "00101001011");
    run_frame("t3_none11", 9'h04A, 4'd8,  2'b11, 1'b0, "0010100101");
    run_frame("t4_odd2",   9'h05A, 4'd8,  2'b01, 1'b1, "001011010111");
    run_frame("t5_len5",   9'h1F3, 4'd5,  2'b00, 1'b0, "0110011");
    run_frame("t5_len2",   9'h1F3, 4'd2,  2'b00, 1'b0, "0110011");
    run_frame("t5_len15",  9'h1F3, 4'd15, 2'b00, 1'b0, "01100111111");
    run_frame("t5_mask",   9'h0F3, 4'd5,  2'b10, 1'b0, "01100111");

    // 6: send held high for three frames, back to back
    vals[0] = 9'h04A; vals[1] = 9'h035; vals[2] = 9'h0C3;
    seq6 = '0; accepts = 0; dones6 = 0; falls6 = 0;
    @(negedge baud_clk);
    reg_data = vals[0]; data_len = 4'd8; parity_type = 2'b00; stop_bits = 1'b0; send = 1'b1;
    rdy_prev = ready; rdy_obs = ready;
    for (int c = 0; c < 32; c++) begin
      @(posedge baud_clk);
      if (send && rdy_prev) accepts++;
      @(negedge baud_clk);
      seq6[c] = data_tx;
      if (done_flag) dones6++;
      if (rdy_obs && !ready) falls6++;
      rdy_obs = ready;
      if (accepts < 3) reg_data = vals[accepts];
      else send = 1'b0;
      rdy_prev = ready;
    end
    check_eq("t6_bits", seq6, bits_of({"0010100101", "0101011001", "0110000111", "11"}));
    check_eq("t6_accepts", 64'(accepts), 64'd3);
    check_eq("t6_dones", 64'(dones6), 64'd3);
    check_eq("t6_ready_lows", 64'(falls6), 64'd2);
    check_eq("t6_idle", 64'(active_flag), 64'd0);
    check_eq("t6_ready_end", 64'(ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
